// File: rtl/stage_param_loader.sv
// Requests one stage of database words, packs each classifier's words into a parameter
// bank for the evaluator, and captures the trailing threshold words.
// Optional feature macro: STAGE_PARAM_CHECK_EN (sticky sequence checker driving o_error).
module stage_param_loader #(
  parameter int ADDR_WIDTH               = 10,
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_CLASSIFIERS_STAGE    = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int NUM_STAGE_THRESHOLD      = 3
) (
  input  logic                                              clk_fpga,
  input  logic                                              reset_fpga,
  input  logic                                              i_start,
  output logic                                              o_rden,
  input  logic                                              i_data_valid,
  input  logic [DATA_WIDTH_12-1:0]                          i_data_database,
  input  logic [ADDR_WIDTH-1:0]                             i_classifier_index,
  input  logic [ADDR_WIDTH-1:0]                             i_tree_index,
  input  logic                                              i_end_count_database_index,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12-1:0] o_params,
  output logic [ADDR_WIDTH-1:0]                             o_tree_index,
  output logic                                              o_params_valid,
  input  logic                                              i_params_ready,
  output logic [NUM_STAGE_THRESHOLD*DATA_WIDTH_12-1:0]      o_stage_threshold,
  output logic                                              o_stage_done,
  output logic                                              o_busy,
  output logic                                              o_error
);
  localparam int NP   = NUM_PARAM_PER_CLASSIFIER;
  localparam int NT   = NUM_STAGE_THRESHOLD;
  localparam int DW   = DATA_WIDTH_12;
  localparam int NMAX = (NP > NT) ? NP : NT;
  localparam int CW   = $clog2(NMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, PRESENT, THRESH, DONE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         req_cnt, slot_cnt, limit;
  logic [ADDR_WIDTH-1:0] cls_cnt;
  logic                  fetching, issue, capture, last_capture, accept, start_ok, last_cls;

  // A capture needs an outstanding request, so stray valids never move the counters.
  always_comb begin
    fetching     = (state == LOAD) || (state == THRESH);
    limit        = (state == THRESH) ? CW'(NT) : CW'(NP);
    issue        = fetching && (req_cnt < limit);
    capture      = fetching && i_data_valid && (slot_cnt < req_cnt);
    last_capture = capture && (slot_cnt == limit - CW'(1));
    accept       = (state == PRESENT) && i_params_ready;
    start_ok     = (state == IDLE) && i_start;
    last_cls     = (cls_cnt == ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = i_start ? LOAD : IDLE;
      LOAD:    state_next = last_capture ? PRESENT : LOAD;
      PRESENT: begin
        if (accept) state_next = last_cls ? THRESH : LOAD;
        else        state_next = PRESENT;
      end
      THRESH:  state_next = last_capture ? DONE : THRESH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state             <= IDLE;
      req_cnt           <= '0;
      slot_cnt          <= '0;
      cls_cnt           <= '0;
      o_rden            <= 1'b0;
      o_params_valid    <= 1'b0;
      o_stage_done      <= 1'b0;
      o_busy            <= 1'b0;
      o_params          <= '0;
      o_stage_threshold <= '0;
    end else begin
      state          <= state_next;
      o_rden         <= issue;
      o_params_valid <= (state_next == PRESENT);
      o_stage_done   <= (state == DONE);
      o_busy         <= (state_next != IDLE);

      if (start_ok) begin
        req_cnt  <= '0;
        slot_cnt <= '0;
        cls_cnt  <= '0;
      end else if (accept) begin
        req_cnt  <= '0;
        slot_cnt <= '0;
        if (!last_cls) cls_cnt <= cls_cnt + ADDR_WIDTH'(1);
      end else begin
        if (issue)   req_cnt  <= req_cnt + CW'(1);
        if (capture) slot_cnt <= slot_cnt + CW'(1);
      end

      // Words land by arrival order; the upstream slot index is never used for placement.
      for (int k = 0; k < NP; k++) begin
        if (capture && (state == LOAD) && (slot_cnt == CW'(k)))
          o_params[DW*k +: DW] <= i_data_database;
      end
      for (int k = 0; k < NT; k++) begin
        if (capture && (state == THRESH) && (slot_cnt == CW'(k)))
          o_stage_threshold[DW*k +: DW] <= i_data_database;
      end
    end
  end

  assign o_tree_index = cls_cnt;

`ifdef STAGE_PARAM_CHECK_EN
  logic seq_err;

  always_comb begin
    seq_err = 1'b0;
    if (capture) begin
      if (i_classifier_index != ADDR_WIDTH'(slot_cnt)) seq_err = 1'b1;
      if ((state == LOAD) && (i_tree_index != cls_cnt)) seq_err = 1'b1;
      if ((state == THRESH) && last_capture && !i_end_count_database_index) seq_err = 1'b1;
    end else if (i_data_valid) begin
      seq_err = 1'b1;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga)  o_error <= 1'b0;
    else if (start_ok) o_error <= 1'b0;
    else if (seq_err)  o_error <= 1'b1;
    else               o_error <= o_error;
  end
`else
  logic unused_check_inputs;
  assign unused_check_inputs = ^{i_classifier_index, i_tree_index, i_end_count_database_index};
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_stage_param_loader.sv
// Bench for stage_param_loader: a database-FIFO word stream plus a stage-level model
// (banks, thresholds, latency formula, error expectation) compared every cycle.
module tb_stage_param_loader;
  localparam int AW      = 10;
  localparam int DW      = 12;
  localparam int NC      = 10;
  localparam int NP      = 19;
  localparam int NT      = 3;
  localparam int NW      = NC * NP + NT;
  localparam int CLS_CYC = NP + 3;
  localparam int LAT     = NC * CLS_CYC + NT + 4;

  logic              clk_fpga = 1'b0;
  logic              reset_fpga = 1'b1;
  logic              i_start = 1'b0;
  logic              i_data_valid = 1'b0;
  logic [DW-1:0]     i_data_database = '0;
  logic [AW-1:0]     i_classifier_index = '0;
  logic [AW-1:0]     i_tree_index = '0;
  logic              i_end_count_database_index = 1'b0;
  logic              i_params_ready = 1'b0;
  logic              o_rden, o_params_valid, o_stage_done, o_busy, o_error;
  logic [NP*DW-1:0]  o_params;
  logic [NT*DW-1:0]  o_stage_threshold;
  logic [AW-1:0]     o_tree_index;

  stage_param_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH_12(DW), .NUM_CLASSIFIERS_STAGE(NC),
    .NUM_PARAM_PER_CLASSIFIER(NP), .NUM_STAGE_THRESHOLD(NT)
  ) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_start(i_start), .o_rden(o_rden),
    .i_data_valid(i_data_valid), .i_data_database(i_data_database),
    .i_classifier_index(i_classifier_index), .i_tree_index(i_tree_index),
    .i_end_count_database_index(i_end_count_database_index), .o_params(o_params),
    .o_tree_index(o_tree_index), .o_params_valid(o_params_valid),
    .i_params_ready(i_params_ready), .o_stage_threshold(o_stage_threshold),
    .o_stage_done(o_stage_done), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk_fpga = ~clk_fpga;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] db [NW];
  int cyc = 0, start_edge = 0, hs = 0, stall = 0, ptr = 0, busy_cnt = 0, last_lat = 0;
  int ready_mode = 0, corrupt_word = -1;
  bit active = 1'b0, done_seen = 1'b0, err_exp = 1'b0;
  bit start_d = 1'b0, valid_d = 1'b0, spur_d = 1'b0, corrupt_d = 1'b0, ready_d = 1'b0;
  bit pv_prev = 1'b0, rden_q = 1'b0;
  bit start_req = 1'b0, spur_req = 1'b0, mid_start = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] exp_bank(input int c);
    logic [NP*DW-1:0] b;
    for (int k = 0; k < NP; k++) b[DW*k +: DW] = db[c*NP + k];
    return b;
  endfunction

  function automatic logic [NT*DW-1:0] exp_thr();
    logic [NT*DW-1:0] t;
    for (int k = 0; k < NT; k++) t[DW*k +: DW] = db[NC*NP + k];
    return t;
  endfunction

  task automatic fill_db(input int mode);
    for (int n = 0; n < NW; n++) db[n] = (mode == 0) ? DW'(n) : DW'($urandom);
  endtask

  // One clock: update model from inputs the DUT just sampled, compare, drive next inputs.
  task automatic step();
    int rel;
    @(posedge clk_fpga);
    cyc++;
    #1;
    if (start_d && !active) begin
      active = 1'b1; start_edge = cyc; hs = 0; stall = 0; ptr = 0;
      busy_cnt = 0; err_exp = 1'b0; done_seen = 1'b0;
    end
    if (valid_d) begin
      if (spur_d || corrupt_d) err_exp = 1'b1;
      if (!spur_d) ptr++;
    end
    if (pv_prev) begin
      if (ready_d) hs++;
      else stall++;
    end

    if (!active) begin
      chk_int("idle rden", int'(o_rden), 0);
      chk_int("idle params_valid", int'(o_params_valid), 0);
      chk_int("idle busy", int'(o_busy), 0);
      chk_int("idle stage_done", int'(o_stage_done), 0);
    end else if (o_busy) begin
      busy_cnt++;
    end
    if (o_params_valid) begin
      if (hs < NC) begin
        if (!pv_prev) begin
          chk_int("bank rise cycle", cyc - start_edge, NP + 2 + CLS_CYC*hs + stall);
          chk_int("words before bank", ptr, (hs + 1) * NP);
        end
        chk("bank params", 256'(o_params), 256'(exp_bank(hs)));
        chk_int("tree index", int'(o_tree_index), hs);
        chk_int("rden during present", int'(o_rden), 0);
        chk_int("busy during present", int'(o_busy), 1);
      end else begin
        chk_int("bank count", hs, NC - 1);
      end
    end
    if (o_stage_done && active) begin
      last_lat = cyc - start_edge + 1;
      chk_int("stage latency", last_lat, LAT + stall);
      chk("thresholds", 256'(o_stage_threshold), 256'(exp_thr()));
      chk("final params", 256'(o_params), 256'(exp_bank(NC - 1)));
      chk_int("words captured", ptr, NW);
      chk_int("banks accepted", hs, NC);
      chk_int("busy cycles", busy_cnt, LAT - 1 + stall);
      chk_int("busy at done", int'(o_busy), 0);
      active = 1'b0;
      done_seen = 1'b1;
    end
`ifdef STAGE_PARAM_CHECK_EN
    chk_int("error flag", int'(o_error), int'(err_exp));
`else
    chk_int("error flag", int'(o_error), 0);
`endif

    spur_d = 1'b0; corrupt_d = 1'b0;
    i_data_valid = rden_q;
    i_data_database = '0; i_classifier_index = '0; i_tree_index = '0;
    i_end_count_database_index = 1'b0;
    if (rden_q) begin
      i_data_database = (ptr < NW) ? db[ptr] : DW'($urandom);
      if (ptr < NC*NP) begin
        i_classifier_index = AW'(ptr % NP);
        i_tree_index = AW'(ptr / NP);
      end else begin
        i_classifier_index = AW'(ptr - NC*NP);
      end
      i_end_count_database_index = (ptr == NW - 1);
      if (ptr == corrupt_word) begin
        i_classifier_index = i_classifier_index ^ AW'(1);
        corrupt_d = 1'b1;
      end
    end else if (spur_req && !active && !start_req) begin
      i_data_valid = 1'b1;
      i_data_database = DW'($urandom);
      spur_d = 1'b1;
      spur_req = 1'b0;
    end
    i_start = 1'b0;
    if (start_req) begin
      i_start = 1'b1; start_req = 1'b0;
    end else if (mid_start && active && (cyc - start_edge == 9)) begin
      i_start = 1'b1; mid_start = 1'b0;
    end
    rel = cyc + 1 - start_edge;
    case (ready_mode)
      1:       i_params_ready = ($urandom_range(0, 3) != 0);
      2:       i_params_ready = !(active && rel >= NP + 2 + CLS_CYC*3 && rel <= NP + 8 + CLS_CYC*3);
      default: i_params_ready = 1'b1;
    endcase
    start_d = i_start; valid_d = i_data_valid; ready_d = i_params_ready;
    pv_prev = o_params_valid; rden_q = o_rden;
  endtask

  task automatic do_reset();
    reset_fpga = 1'b0;
    i_start = 1'b0; i_data_valid = 1'b0; i_params_ready = 1'b0;
    #1;
    chk_int("reset rden", int'(o_rden), 0);
    chk_int("reset params_valid", int'(o_params_valid), 0);
    chk_int("reset stage_done", int'(o_stage_done), 0);
    chk_int("reset busy", int'(o_busy), 0);
    chk_int("reset error", int'(o_error), 0);
    chk("reset params", 256'(o_params), 256'(0));
    chk("reset thresholds", 256'(o_stage_threshold), 256'(0));
    chk_int("reset tree index", int'(o_tree_index), 0);
    active = 1'b0; err_exp = 1'b0; mid_start = 1'b0;
    start_d = 1'b0; valid_d = 1'b0; spur_d = 1'b0; corrupt_d = 1'b0;
    pv_prev = 1'b0; rden_q = 1'b0;
    repeat (2) @(posedge clk_fpga);
    cyc += 2;
    #2 reset_fpga = 1'b1;
  endtask

  task automatic run_stage(input int rmode, input bit mid, input int abort_at);
    ready_mode = rmode; mid_start = mid; start_req = 1'b1; done_seen = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      step();
      if (abort_at >= 0 && active && ptr == abort_at) begin
        do_reset();
        return;
      end
      if (done_seen) break;
    end
    chk_int("stage completes", int'(done_seen), 1);
  endtask

  initial begin
    #2;
    do_reset();

    fill_db(0);
    run_stage(0, 1'b0, -1);
    chk_int("nominal latency literal", last_lat, 227);
    chk("nominal thresholds literal", 256'(o_stage_threshold), 256'({12'd192, 12'd191, 12'd190}));
    chk_int("last bank slot0 literal", int'(o_params[11:0]), 171);
    chk_int("last bank slot18 literal", int'(o_params[18*12 +: 12]), 189);
    chk_int("last tree index literal", int'(o_tree_index), 9);

    spur_req = 1'b1;
    repeat (4) step();
    chk("idle params hold", 256'(o_params), 256'(exp_bank(NC - 1)));
    chk("idle thresholds hold", 256'(o_stage_threshold), 256'(exp_thr()));
`ifdef STAGE_PARAM_CHECK_EN
    chk_int("spurious valid error literal", int'(o_error), 1);
`else
    chk_int("spurious valid error literal", int'(o_error), 0);
`endif

    fill_db(1);
    run_stage(2, 1'b0, -1);
    chk_int("backpressure latency literal", last_lat, 233);

    fill_db(0);
    run_stage(0, 1'b0, 2*NP + 5);
    repeat (3) step();
    run_stage(0, 1'b0, -1);
    chk_int("restart latency literal", last_lat, 227);
    chk("restart thresholds literal", 256'(o_stage_threshold), 256'({12'd192, 12'd191, 12'd190}));

    corrupt_word = 40;
    run_stage(1, 1'b1, -1);
    corrupt_word = -1;
`ifdef STAGE_PARAM_CHECK_EN
    chk_int("corrupt index error literal", int'(o_error), 1);
`else
    chk_int("corrupt index error literal", int'(o_error), 0);
`endif

    for (int s = 0; s < 3; s++) begin
      fill_db(1);
      repeat ($urandom_range(1, 5)) step();
      run_stage(1, (s % 2) == 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
